// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Condition-code register, conditional branch evaluation, PC
//                redirect pulse and wrong-path flush window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flag_we,
    input  logic [3:0]      flag_in,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            stall_in,
    output logic            br_ready,
    output logic            taken,
    output logic [PC_W-1:0] target_pc,
    output logic            flush,
    output logic [3:0]      flags
);

    localparam logic [3:0] c_cnt_load = 4'(FLUSH_CYCLES - 1);

    localparam logic [2:0] c_be     = 3'd0;
    localparam logic [2:0] c_blt    = 3'd1;
    localparam logic [2:0] c_ble    = 3'd2;
    localparam logic [2:0] c_bne    = 3'd3;
    localparam logic [2:0] c_always = 3'd7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [3:0]      r_flags;
    logic            r_taken;
    logic [PC_W-1:0] r_target_pc;

    logic w_flag_wr;
    logic w_accept;
    logic w_cond_true;
    logic w_take;
    logic w_s, w_z, w_v, w_lt;

    // Writes arriving during the flush window belong to squashed instructions.
    assign w_flag_wr = flag_we && !stall_in && (r_state != FLUSH);
    assign br_ready  = (r_state == IDLE) && !stall_in;
    assign w_accept  = br_valid && br_ready;

    // Same-cycle bypass lets a branch see the flags its predecessor just produced.
    assign w_s  = w_flag_wr ? flag_in[3] : r_flags[3];
    assign w_z  = w_flag_wr ? flag_in[2] : r_flags[2];
    assign w_v  = w_flag_wr ? flag_in[0] : r_flags[0];
    assign w_lt = w_s ^ w_v;

    always_comb begin
        w_cond_true = 1'b0;
        case (br_cond)
            c_be:     w_cond_true = w_z;
            c_blt:    w_cond_true = w_lt;
            c_ble:    w_cond_true = w_z | w_lt;
            c_bne:    w_cond_true = !w_z;
            c_always: w_cond_true = 1'b1;
            default:  w_cond_true = 1'b0;
        endcase
    end

    assign w_take = w_accept && w_cond_true;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags     <= 4'b0000;
            r_taken     <= 1'b0;
            r_target_pc <= '0;
        end else begin
            if (w_flag_wr) begin
                r_flags <= flag_in;
            end
            r_taken <= w_take;
            if (w_take) begin
                r_target_pc <= br_target;
            end
        end
    end

    assign taken     = r_taken;
    assign target_pc = r_target_pc;
    assign flush     = (r_state == FLUSH);
    assign flags     = r_flags;

endmodule

`default_nettype wire
